// File: rtl/uart_tx_framer.sv
// UART transmit framer: takes one byte per valid/ready handshake and serialises
// start, LSB-first data, optional parity and stop bits, one bit per baud tick.
module uart_tx_framer #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       baud_ena,
  input  logic       baud_tick,
  output logic       tx,
  output logic       tx_done
);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_tx_framer: illegal DATA_BITS/PARITY/STOP_BITS combination");
  end

  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, ARM, START, DATA, PAR, STOP} state_t;

  state_t     state_reg;
  logic [7:0] data_reg;
  logic       parity_reg;
  logic [2:0] bit_cnt_reg;
  logic       stop_cnt_reg;
  logic       tx_reg;
  logic       baud_ena_reg;
  logic       tx_done_reg;

  logic [7:0] data_masked;
  logic       parity_next;

  // Unused upper data bits are dropped at accept so they never reach the line or parity.
  assign data_masked = tx_data & DATA_MASK;
  assign parity_next = (PARITY == 1) ? ~(^data_masked) : (^data_masked);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      data_reg     <= '0;
      parity_reg   <= 1'b0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      tx_reg       <= 1'b1;
      baud_ena_reg <= 1'b0;
      tx_done_reg  <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A tick arriving together with the accept is deliberately not consumed here.
          if (tx_valid) begin
            data_reg     <= data_masked;
            parity_reg   <= parity_next;
            baud_ena_reg <= 1'b1;
            state_reg    <= ARM;
          end
        end
        ARM: begin
          if (baud_tick) begin
            state_reg <= START;
            tx_reg    <= 1'b0;
          end
        end
        START: begin
          if (baud_tick) begin
            state_reg   <= DATA;
            tx_reg      <= data_reg[0];
            bit_cnt_reg <= '0;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt_reg == LAST_BIT) begin
              if (PARITY != 0) begin
                state_reg <= PAR;
                tx_reg    <= parity_reg;
              end else begin
                state_reg    <= STOP;
                tx_reg       <= 1'b1;
                stop_cnt_reg <= 1'b0;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              tx_reg      <= data_reg[bit_cnt_reg + 3'd1];
            end
          end
        end
        PAR: begin
          if (baud_tick) begin
            state_reg    <= STOP;
            tx_reg       <= 1'b1;
            stop_cnt_reg <= 1'b0;
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (stop_cnt_reg == LAST_STOP) begin
              state_reg    <= IDLE;
              baud_ena_reg <= 1'b0;
              tx_done_reg  <= 1'b1;
            end else begin
              stop_cnt_reg <= stop_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          tx_reg       <= 1'b1;
          baud_ena_reg <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = (state_reg == IDLE);
  assign baud_ena = baud_ena_reg;
  assign tx       = tx_reg;
  assign tx_done  = tx_done_reg;

endmodule
